// File: rtl/polara_loopback_checker_if.sv
// Flit streams returning from the chip on NoC1..3, each a val/rdy handshake.
// The master drives data/val; the checker (slave) drives rdy.
interface polara_loopback_checker_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] intf_chipset_data_noc1;
  logic [DATA_W-1:0] intf_chipset_data_noc2;
  logic [DATA_W-1:0] intf_chipset_data_noc3;
  logic              intf_chipset_val_noc1;
  logic              intf_chipset_val_noc2;
  logic              intf_chipset_val_noc3;
  logic              intf_chipset_rdy_noc1;
  logic              intf_chipset_rdy_noc2;
  logic              intf_chipset_rdy_noc3;

  modport master (
    output intf_chipset_data_noc1, intf_chipset_data_noc2, intf_chipset_data_noc3,
    output intf_chipset_val_noc1, intf_chipset_val_noc2, intf_chipset_val_noc3,
    input  intf_chipset_rdy_noc1, intf_chipset_rdy_noc2, intf_chipset_rdy_noc3
  );

  modport slave (
    input  intf_chipset_data_noc1, intf_chipset_data_noc2, intf_chipset_data_noc3,
    input  intf_chipset_val_noc1, intf_chipset_val_noc2, intf_chipset_val_noc3,
    output intf_chipset_rdy_noc1, intf_chipset_rdy_noc2, intf_chipset_rdy_noc3
  );
endinterface

// File: rtl/polara_loopback_checker.sv
// Sinks loopback NoC traffic, checks OpenPiton headers on one channel and keeps statistics.
// Define POLARA_LB_CHK_TIMEOUT_EN to abort packets that stall for TIMEOUT_CYC cycles.
module polara_loopback_checker #(
  parameter int             DATA_W       = 64,
  parameter int             CNT_W        = 16,
  parameter logic [13:0]    EXP_CHIPID   = 14'h2000,
  parameter logic [3:0]     EXP_FBITS    = 4'b0010,
  parameter logic [7:0]     EXP_MSG_TYPE = 8'd18,
  parameter int             TIMEOUT_CYC  = 1024
) (
  input  logic                   chipset_clk,
  input  logic                   chipset_rst,
  input  logic [1:0]             chan_sel,
  input  logic                   stat_clr,
  polara_loopback_checker_if.slave noc,
  output logic [CNT_W-1:0]       pkt_ok_cnt,
  output logic [CNT_W-1:0]       pkt_err_cnt,
  output logic [CNT_W-1:0]       flit_cnt,
  output logic [DATA_W-1:0]      last_bad_hdr,
  output logic                   err_sticky,
  output logic                   in_packet
);

  typedef enum logic {
    ST_HDR,
    ST_PAYLOAD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  generate
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
    end
  endgenerate

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_t              state_q, state_d;
  logic [7:0]          rem_q, rem_d;
  logic [1:0]          chan_sel_q;
  logic [CNT_W-1:0]    ok_q, ok_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [CNT_W-1:0]    flit_q, flit_d;
  logic [DATA_W-1:0]   bad_q, bad_d;
  logic                sticky_q, sticky_d;

  logic                rdy;
  logic                sel_val;
  logic [DATA_W-1:0]   sel_data;
  logic                acc;
  logic                chan_chg;
  logic                hdr_match;
  logic [7:0]          hdr_len;
  logic                inc_ok, inc_err, inc_flit, cap_bad;

`ifdef POLARA_LB_CHK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0]   idle_q, idle_d;
`endif

  // The sink never back-pressures; ready simply follows reset release.
  assign rdy = ~chipset_rst;
  assign noc.intf_chipset_rdy_noc1 = rdy;
  assign noc.intf_chipset_rdy_noc2 = rdy;
  assign noc.intf_chipset_rdy_noc3 = rdy;

  always_comb begin
    sel_val  = 1'b0;
    sel_data = '0;
    case (chan_sel)
      2'b01: begin
        sel_val  = noc.intf_chipset_val_noc1;
        sel_data = noc.intf_chipset_data_noc1;
      end
      2'b10: begin
        sel_val  = noc.intf_chipset_val_noc2;
        sel_data = noc.intf_chipset_data_noc2;
      end
      2'b11: begin
        sel_val  = noc.intf_chipset_val_noc3;
        sel_data = noc.intf_chipset_data_noc3;
      end
      default: begin
        sel_val  = 1'b0;
        sel_data = '0;
      end
    endcase
  end

  assign acc       = sel_val & rdy;
  assign chan_chg  = (chan_sel != chan_sel_q);
  assign hdr_len   = sel_data[29:22];
  assign hdr_match = (sel_data[63:50] == EXP_CHIPID) &&
                     (sel_data[33:30] == EXP_FBITS) &&
                     (sel_data[21:14] == EXP_MSG_TYPE) &&
                     (sel_data[5:0] == 6'd0);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    inc_ok   = 1'b0;
    inc_err  = 1'b0;
    inc_flit = 1'b0;
    cap_bad  = 1'b0;
`ifdef POLARA_LB_CHK_TIMEOUT_EN
    idle_d   = idle_q;
`endif
    // A channel switch (or no channel) abandons any partial packet silently.
    if (chan_chg || (chan_sel == 2'b00)) begin
      state_d = ST_HDR;
`ifdef POLARA_LB_CHK_TIMEOUT_EN
      idle_d  = '0;
`endif
    end else begin
      case (state_q)
        ST_HDR: begin
          if (acc) begin
            inc_flit = 1'b1;
            inc_ok   = hdr_match;
            inc_err  = ~hdr_match;
            cap_bad  = ~hdr_match;
            if (hdr_len != 8'd0) begin
              state_d = ST_PAYLOAD;
              rem_d   = hdr_len;
`ifdef POLARA_LB_CHK_TIMEOUT_EN
              idle_d  = '0;
`endif
            end
          end
        end
        ST_PAYLOAD: begin
          if (acc) begin
            inc_flit = 1'b1;
            rem_d    = rem_q - 8'd1;
`ifdef POLARA_LB_CHK_TIMEOUT_EN
            idle_d   = '0;
`endif
            if (rem_q == 8'd1) begin
              state_d = ST_HDR;
            end
          end else begin
`ifdef POLARA_LB_CHK_TIMEOUT_EN
            if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
              inc_err = 1'b1;
              state_d = ST_HDR;
              idle_d  = '0;
            end else begin
              idle_d  = idle_q + 1'b1;
            end
`endif
          end
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  // Statistics: clear has priority over any same-cycle increment.
  always_comb begin
    ok_d     = inc_ok   ? sat_inc(ok_q)   : ok_q;
    err_d    = inc_err  ? sat_inc(err_q)  : err_q;
    flit_d   = inc_flit ? sat_inc(flit_q) : flit_q;
    bad_d    = cap_bad  ? sel_data        : bad_q;
    sticky_d = sticky_q | inc_err;
    if (stat_clr) begin
      ok_d     = '0;
      err_d    = '0;
      flit_d   = '0;
      bad_d    = '0;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      state_q    <= ST_HDR;
      rem_q      <= 8'd0;
      chan_sel_q <= chan_sel;
      ok_q       <= '0;
      err_q      <= '0;
      flit_q     <= '0;
      bad_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      chan_sel_q <= chan_sel;
      ok_q       <= ok_d;
      err_q      <= err_d;
      flit_q     <= flit_d;
      bad_q      <= bad_d;
      sticky_q   <= sticky_d;
    end
  end

`ifdef POLARA_LB_CHK_TIMEOUT_EN
  always_ff @(posedge chipset_clk) begin
    if (chipset_rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  assign pkt_ok_cnt   = ok_q;
  assign pkt_err_cnt  = err_q;
  assign flit_cnt     = flit_q;
  assign last_bad_hdr = bad_q;
  assign err_sticky   = sticky_q;
  assign in_packet    = (state_q == ST_PAYLOAD);

endmodule

// File: tb/tb_polara_loopback_checker.sv
// Randomized and directed bench for polara_loopback_checker against a packet-level model.
// Honours POLARA_LB_CHK_TIMEOUT_EN the same way the design does.
module tb_polara_loopback_checker;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 8;
  localparam int TMO    = 16;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        chan_sel;
  logic              stat_clr;
  logic [63:0]       d [1:3];
  logic              v [1:3];

  logic [CNT_W-1:0]  pkt_ok_cnt, pkt_err_cnt, flit_cnt;
  logic [DATA_W-1:0] last_bad_hdr;
  logic              err_sticky, in_packet;

  polara_loopback_checker_if #(.DATA_W(DATA_W)) nif ();

  assign nif.intf_chipset_data_noc1 = d[1];
  assign nif.intf_chipset_data_noc2 = d[2];
  assign nif.intf_chipset_data_noc3 = d[3];
  assign nif.intf_chipset_val_noc1  = v[1];
  assign nif.intf_chipset_val_noc2  = v[2];
  assign nif.intf_chipset_val_noc3  = v[3];

  polara_loopback_checker #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .chipset_clk  (clk),
    .chipset_rst  (rst),
    .chan_sel     (chan_sel),
    .stat_clr     (stat_clr),
    .noc          (nif),
    .pkt_ok_cnt   (pkt_ok_cnt),
    .pkt_err_cnt  (pkt_err_cnt),
    .flit_cnt     (flit_cnt),
    .last_bad_hdr (last_bad_hdr),
    .err_sticky   (err_sticky),
    .in_packet    (in_packet)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Packet-level reference state.
  int          m_ok, m_err, m_flit, m_rem, m_idle;
  logic [63:0] m_bad;
  bit          m_sticky, m_inpkt;
  logic [1:0]  m_prev;

  function automatic int sinc(input int x);
    return (x < MAXC) ? x + 1 : x;
  endfunction

  function automatic bit hdr_good(input logic [63:0] h);
    return (h[63:50] == 14'h2000) && (h[33:30] == 4'b0010) &&
           (h[21:14] == 8'd18) && (h[5:0] == 6'd0);
  endfunction

  function automatic logic [63:0] make_hdr(input bit good, input int len);
    logic [63:0] h;
    h = {14'h2000, 8'($urandom), 8'($urandom), 4'b0010, 8'(len), 8'd18,
         8'($urandom), 6'd0};
    if (!good) begin
      case ($urandom_range(0, 3))
        0: h[63:50] = h[63:50] ^ 14'(1 << $urandom_range(0, 13));
        1: h[33:30] = h[33:30] ^ 4'(1 << $urandom_range(0, 3));
        2: h[21:14] = 8'd20;
        default: h[5:0] = 6'(1 << $urandom_range(0, 5));
      endcase
    end
    return h;
  endfunction

  task automatic model_step();
    logic [63:0] fd;
    bit          fv;
    if (rst) begin
      m_ok = 0; m_err = 0; m_flit = 0; m_rem = 0; m_idle = 0;
      m_bad = '0; m_sticky = 0; m_inpkt = 0; m_prev = chan_sel;
      return;
    end
    fv = 0;
    fd = '0;
    if (chan_sel != 2'b00) begin
      fv = v[chan_sel];
      fd = d[chan_sel];
    end
    if (chan_sel != m_prev || chan_sel == 2'b00) begin
      m_inpkt = 0;
      m_idle  = 0;
    end else if (fv) begin
      m_flit = sinc(m_flit);
      if (!m_inpkt) begin
        if (hdr_good(fd)) m_ok = sinc(m_ok);
        else begin
          m_err = sinc(m_err); m_sticky = 1; m_bad = fd;
        end
        if (fd[29:22] != 0) begin
          m_inpkt = 1; m_rem = int'(fd[29:22]); m_idle = 0;
        end
      end else begin
        m_rem--;
        m_idle = 0;
        if (m_rem == 0) m_inpkt = 0;
      end
    end else if (m_inpkt) begin
`ifdef POLARA_LB_CHK_TIMEOUT_EN
      m_idle++;
      if (m_idle == TMO) begin
        m_err = sinc(m_err); m_sticky = 1; m_inpkt = 0; m_idle = 0;
      end
`endif
    end
    m_prev = chan_sel;
    if (stat_clr) begin
      m_ok = 0; m_err = 0; m_flit = 0; m_bad = '0; m_sticky = 0;
    end
  endtask

  task automatic check_all();
    chk("rdy1", 64'(nif.intf_chipset_rdy_noc1), 64'(!rst));
    chk("rdy2", 64'(nif.intf_chipset_rdy_noc2), 64'(!rst));
    chk("rdy3", 64'(nif.intf_chipset_rdy_noc3), 64'(!rst));
    chk("pkt_ok", 64'(pkt_ok_cnt), 64'(m_ok));
    chk("pkt_err", 64'(pkt_err_cnt), 64'(m_err));
    chk("flit", 64'(flit_cnt), 64'(m_flit));
    chk("last_bad", last_bad_hdr, m_bad);
    chk("sticky", 64'(err_sticky), 64'(m_sticky));
    chk("in_packet", 64'(in_packet), 64'(m_inpkt));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_all();
    for (int c = 1; c <= 3; c++) v[c] = 1'b0;
  endtask

  task automatic send(input int ch, input logic [63:0] flit);
    idle_all();
    v[ch] = 1'b1;
    d[ch] = flit;
    cycle();
    v[ch] = 1'b0;
  endtask

  task automatic set_sel(input logic [1:0] s);
    chan_sel = s;
    cycle();
  endtask

  task automatic clear_stats();
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
  endtask

  logic [63:0] hdr;
  int          base_err;

  initial begin
    rst = 1'b1; chan_sel = 2'b01; stat_clr = 1'b0;
    for (int c = 1; c <= 3; c++) begin d[c] = '0; v[c] = 1'b0; end
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    chk("reset_ok", 64'(pkt_ok_cnt), 64'd0);

    // Good header, len 0, on NoC1.
    send(1, make_hdr(1, 0));
    chk("t1_ok", 64'(pkt_ok_cnt), 64'd1);
    chk("t1_flit", 64'(flit_cnt), 64'd1);
    chk("t1_sticky", 64'(err_sticky), 64'd0);

    // Wrong message type on NoC2.
    set_sel(2'b10);
    hdr = make_hdr(1, 0);
    hdr[21:14] = 8'd20;
    send(2, hdr);
    chk("t2_err", 64'(pkt_err_cnt), 64'd1);
    chk("t2_sticky", 64'(err_sticky), 64'd1);
    chk("t2_bad_hdr", last_bad_hdr, hdr);

    // len 3 packet with val toggling every other cycle.
    set_sel(2'b01);
    clear_stats();
    send(1, make_hdr(1, 3));
    for (int i = 0; i < 3; i++) begin
      chk("t3_inpkt", 64'(in_packet), 64'd1);
      cycle();
      send(1, 64'($urandom) << 32 | 64'($urandom));
    end
    chk("t3_ok", 64'(pkt_ok_cnt), 64'd1);
    chk("t3_flit", 64'(flit_cnt), 64'd4);
    chk("t3_hdr_state", 64'(in_packet), 64'd0);

    // Traffic on an unselected channel is dropped.
    for (int i = 0; i < 4; i++) send(3, make_hdr(i[0], 0));
    chk("t4_flit", 64'(flit_cnt), 64'd4);

    // Channel switch mid-packet.
    clear_stats();
    send(1, make_hdr(1, 5));
    send(1, 64'h1111);
    send(1, 64'h2222);
    set_sel(2'b10);
    chk("t5_inpkt", 64'(in_packet), 64'd0);
    chk("t5_ok", 64'(pkt_ok_cnt), 64'd1);
    chk("t5_err", 64'(pkt_err_cnt), 64'd0);

    // Stalled packet.
    base_err = int'(pkt_err_cnt);
    send(2, make_hdr(1, 2));
    idle_all();
    repeat (TMO) cycle();
`ifdef POLARA_LB_CHK_TIMEOUT_EN
    chk("t6_inpkt", 64'(in_packet), 64'd0);
    chk("t6_err", 64'(pkt_err_cnt), 64'(base_err + 1));
`else
    chk("t6_inpkt", 64'(in_packet), 64'd1);
    chk("t6_err", 64'(pkt_err_cnt), 64'(base_err));
`endif
    set_sel(2'b01);

    // stat_clr coinciding with a good header.
    stat_clr = 1'b1;
    send(1, make_hdr(1, 0));
    stat_clr = 1'b0;
    chk("t7_ok", 64'(pkt_ok_cnt), 64'd0);
    chk("t7_flit", 64'(flit_cnt), 64'd0);

    // Saturation.
    for (int i = 0; i < MAXC + 5; i++) send(1, make_hdr(1, 0));
    chk("t8_ok_sat", 64'(pkt_ok_cnt), 64'(MAXC));
    chk("t8_flit_sat", 64'(flit_cnt), 64'(MAXC));
    clear_stats();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 63) == 0) chan_sel = 2'($urandom);
      stat_clr = ($urandom_range(0, 49) == 0);
      rst      = ($urandom_range(0, 399) == 0);
      for (int c = 1; c <= 3; c++) begin
        v[c] = ($urandom_range(0, 2) != 0);
        if (c == int'(chan_sel) && !m_inpkt)
          d[c] = make_hdr($urandom_range(0, 3) != 0, $urandom_range(0, 3));
        else
          d[c] = {32'($urandom), 32'($urandom)};
      end
      cycle();
    end
    rst = 1'b0; stat_clr = 1'b0;
    idle_all();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
